// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: load-use interlock, multi-cycle divider stall,
// branch/exception flushes and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned REG_LOG = 5,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [3*REG_LOG-1:0] rs_ID,
  input  logic [2:0]           rs_use_ID,
  input  logic [REG_LOG-1:0]   rd_EX,
  input  logic                 MEM_read_EX,
  input  logic                 div_start_EX,
  input  logic                 br_taken_EX,
  input  logic                 excp_flush,
  output logic                 stall_IF,
  output logic                 stall_ID,
  output logic                 stall_EX,
  output logic                 flush_ID,
  output logic                 flush_EX,
  output logic                 flush_MEM,
  output logic                 div_done,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned DivCntW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [DivCntW-1:0] DivLoad = DivCntW'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDivRun  = 2'd1,
    StDivDone = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DivCntW-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               lu;

  always_comb begin
    lu = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rs_use_ID[i] && (rs_ID[i*REG_LOG +: REG_LOG] == rd_EX)) lu = 1'b1;
    end
    lu = lu & MEM_read_EX & (|rd_EX);
  end

  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    flush_MEM = 1'b0;
    div_done  = 1'b0;
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    if (!rstn) begin
      // Controls stay low during reset; the registers are cleared in always_ff.
      state_d = StIdle;
    end else if (excp_flush) begin
      flush_ID  = 1'b1;
      flush_EX  = 1'b1;
      flush_MEM = 1'b1;
      state_d   = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (div_start_EX) begin
            // The accepting cycle already counts as the first stall cycle.
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            stall_EX  = 1'b1;
            flush_MEM = 1'b1;
            state_d   = StDivRun;
            div_cnt_d = DivLoad;
          end else if (br_taken_EX) begin
            flush_ID = 1'b1;
            flush_EX = 1'b1;
          end else if (lu) begin
            stall_IF = 1'b1;
            stall_ID = 1'b1;
            flush_EX = 1'b1;
          end
        end
        StDivRun: begin
          stall_IF  = 1'b1;
          stall_ID  = 1'b1;
          stall_EX  = 1'b1;
          flush_MEM = 1'b1;
          if (div_cnt_q == '0) begin
            state_d = StDivDone;
          end else begin
            div_cnt_d = div_cnt_q - 1'b1;
          end
        end
        StDivDone: begin
          div_done = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_IF && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      div_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table vectors, directed divider/flush/reset sequences and random
// stimulus against a cycle-count reference model; a 4-bit counter copy checks saturation.
module tb_hazard_ctrl;

  localparam int unsigned RegLog = 5;
  localparam int unsigned DivLat = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [3*RegLog-1:0] rs_ID;
  logic [2:0]        rs_use_ID;
  logic [RegLog-1:0] rd_EX;
  logic              MEM_read_EX, div_start_EX, br_taken_EX, excp_flush;

  logic s_if, s_id, s_ex, f_id, f_ex, f_mem, d_done;
  logic [1:0]  st;
  logic [31:0] cnt;
  logic s_if2, s_id2, s_ex2, f_id2, f_ex2, f_mem2, d_done2;
  logic [1:0]  st2;
  logic [3:0]  cnt4;

  hazard_ctrl #(.REG_LOG(RegLog), .DIV_LAT(DivLat), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .rs_ID(rs_ID), .rs_use_ID(rs_use_ID), .rd_EX(rd_EX),
    .MEM_read_EX(MEM_read_EX), .div_start_EX(div_start_EX), .br_taken_EX(br_taken_EX),
    .excp_flush(excp_flush), .stall_IF(s_if), .stall_ID(s_id), .stall_EX(s_ex),
    .flush_ID(f_id), .flush_EX(f_ex), .flush_MEM(f_mem), .div_done(d_done), .state(st),
    .stall_cnt(cnt)
  );

  hazard_ctrl #(.REG_LOG(RegLog), .DIV_LAT(DivLat), .CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .rs_ID(rs_ID), .rs_use_ID(rs_use_ID), .rd_EX(rd_EX),
    .MEM_read_EX(MEM_read_EX), .div_start_EX(div_start_EX), .br_taken_EX(br_taken_EX),
    .excp_flush(excp_flush), .stall_IF(s_if2), .stall_ID(s_id2), .stall_EX(s_ex2),
    .flush_ID(f_id2), .flush_EX(f_ex2), .flush_MEM(f_mem2), .div_done(d_done2), .state(st2),
    .stall_cnt(cnt4)
  );

  // {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, flush_MEM, div_done}
  logic [6:0] ctrl;
  assign ctrl = {s_if, s_id, s_ex, f_id, f_ex, f_mem, d_done};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remaining divider busy cycles, a done flag, and plain stall tallies.
  int     run_left = 0;
  bit     done_m   = 0;
  longint m_cnt32  = 0;
  int     m_cnt4   = 0;

  function automatic logic [6:0] m_ctrl();
    logic lu = 1'b0;
    for (int i = 0; i < 3; i++)
      if (rs_use_ID[i] && rs_ID[i*RegLog +: RegLog] == rd_EX) lu = 1'b1;
    lu = lu && MEM_read_EX && (rd_EX != 0);
    if (!rstn)        return 7'b0000000;
    if (excp_flush)   return 7'b0001110;
    if (run_left > 0) return 7'b1110010;
    if (done_m)       return 7'b0000001;
    if (div_start_EX) return 7'b1110010;
    if (br_taken_EX)  return 7'b0001100;
    if (lu)           return 7'b1100100;
    return 7'b0000000;
  endfunction

  function automatic logic [1:0] m_state();
    if (run_left > 0) return 2'd1;
    if (done_m) return 2'd2;
    return 2'd0;
  endfunction

  task automatic settle(input string tag);
    #1;
    chk({tag, ".ctrl"}, 64'(ctrl), 64'(m_ctrl()));
    chk({tag, ".state"}, 64'(st), 64'(m_state()));
    chk({tag, ".cnt"}, 64'(cnt), 64'(m_cnt32));
    chk({tag, ".cnt4"}, 64'(cnt4), 64'(m_cnt4));
  endtask

  task automatic tick();
    logic stall_now;
    stall_now = m_ctrl()[6];
    @(posedge clk);
    if (!rstn) begin
      run_left = 0; done_m = 0; m_cnt32 = 0; m_cnt4 = 0;
    end else begin
      if (stall_now) begin
        if (m_cnt32 < 64'hFFFF_FFFF) m_cnt32++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (excp_flush) begin
        run_left = 0; done_m = 0;
      end else if (run_left > 0) begin
        run_left--;
        if (run_left == 0) done_m = 1;
      end else if (done_m) begin
        done_m = 0;
      end else if (div_start_EX) begin
        run_left = DivLat;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs_ID = '0; rs_use_ID = '0; rd_EX = '0;
    MEM_read_EX = 0; div_start_EX = 0; br_taken_EX = 0; excp_flush = 0;
  endtask

  typedef struct {
    logic [3*RegLog-1:0] rs;
    logic [2:0]          ruse;
    logic [RegLog-1:0]   rd;
    logic                mr, br, ex;
    logic [6:0]          exp;
  } vec_t;

  vec_t tbl[10];
  longint cnt_before;
  int     nstall;
  bit     seen_done;

  initial begin
    tbl[0] = '{{5'd0, 5'd5, 5'd0}, 3'b010, 5'd5, 1, 0, 0, 7'b1100100};
    tbl[1] = '{{5'd0, 5'd0, 5'd0}, 3'b010, 5'd0, 1, 0, 0, 7'b0000000};
    tbl[2] = '{{5'd0, 5'd5, 5'd0}, 3'b001, 5'd5, 1, 0, 0, 7'b0000000};
    tbl[3] = '{{5'd0, 5'd5, 5'd0}, 3'b010, 5'd5, 0, 0, 0, 7'b0000000};
    tbl[4] = '{{5'd0, 5'd0, 5'd3}, 3'b001, 5'd3, 1, 1, 0, 7'b0001100};
    tbl[5] = '{{5'd0, 5'd0, 5'd3}, 3'b001, 5'd3, 1, 0, 0, 7'b1100100};
    tbl[6] = '{{5'd7, 5'd0, 5'd0}, 3'b100, 5'd7, 1, 0, 0, 7'b1100100};
    tbl[7] = '{{5'd7, 5'd0, 5'd0}, 3'b100, 5'd7, 1, 0, 1, 7'b0001110};
    tbl[8] = '{{5'd0, 5'd0, 5'd0}, 3'b000, 5'd1, 0, 1, 0, 7'b0001100};
    tbl[9] = '{{5'd9, 5'd9, 5'd9}, 3'b111, 5'd8, 1, 0, 0, 7'b0000000};

    rstn = 0;
    idle_inputs();
    @(negedge clk);
    tick();
    settle("reset");
    chk("reset.ctrl_zero", 64'(ctrl), 64'd0);
    rstn = 1;

    // Table vectors, all applied from IDLE.
    for (int i = 0; i < 10; i++) begin
      rs_ID = tbl[i].rs; rs_use_ID = tbl[i].ruse; rd_EX = tbl[i].rd;
      MEM_read_EX = tbl[i].mr; br_taken_EX = tbl[i].br; excp_flush = tbl[i].ex;
      settle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.exp", i), 64'(ctrl), 64'(tbl[i].exp));
      tick();
    end
    idle_inputs();
    settle("tbl_end");
    chk("lu_cnt", 64'(cnt), 64'd3);

    // Divide held high: 17 stall cycles, one DONE cycle, then a back-to-back divide.
    for (int rep = 0; rep < 2; rep++) begin
      cnt_before = m_cnt32;
      div_start_EX = 1;
      nstall = 0;
      seen_done = 0;
      for (int k = 0; k < 40 && !seen_done; k++) begin
        settle("div");
        if (d_done) begin
          seen_done = 1;
          chk("div.done_nostall", 64'(ctrl), 64'b0000001);
        end else if (s_if) begin
          nstall++;
        end
        tick();
      end
      chk("div.done_seen", 64'(seen_done), 64'd1);
      chk("div.nstall", 64'(nstall), 64'(DivLat + 1));
      chk("div.cnt_delta", 64'(cnt) - 64'(cnt_before), 64'(DivLat + 1));
      chk("div.state_idle", 64'(st), 64'd0);
    end
    div_start_EX = 0;
    settle("div_end");
    tick();

    // Exception on the 5th DIV_RUN cycle aborts the divide.
    div_start_EX = 1;
    settle("ex.acc"); tick();
    for (int k = 0; k < 4; k++) begin settle("ex.run"); tick(); end
    excp_flush = 1;
    settle("ex.hit");
    chk("ex.flushes", 64'(ctrl), 64'b0001110);
    tick();
    excp_flush = 0; div_start_EX = 0;
    settle("ex.after");
    chk("ex.state", 64'(st), 64'd0);
    seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      settle("ex.tail");
      if (d_done) seen_done = 1;
      tick();
    end
    chk("ex.no_done", 64'(seen_done), 64'd0);

    // Reset in the middle of a divide.
    div_start_EX = 1;
    settle("rs.acc"); tick();
    div_start_EX = 0;
    for (int k = 0; k < 3; k++) begin settle("rs.run"); tick(); end
    rstn = 0;
    settle("rs.low");
    chk("rs.ctrl_zero", 64'(ctrl), 64'd0);
    tick();
    chk("rs.state", 64'(st), 64'd0);
    chk("rs.cnt", 64'(cnt), 64'd0);
    rstn = 1;
    settle("rs.back");

    // Saturation of the 4-bit copy.
    div_start_EX = 1;
    for (int k = 0; k < 25; k++) begin settle("sat"); tick(); end
    div_start_EX = 0;
    settle("sat.end");
    chk("sat.cnt4", 64'(cnt4), 64'd15);
    chk("sat.cnt32_gt15", 64'(cnt > 15), 64'd1);

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      rs_ID = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rs_use_ID = 3'($urandom);
      rd_EX = 5'($urandom_range(0, 3));
      MEM_read_EX = ($urandom_range(0, 1) == 1);
      div_start_EX = ($urandom_range(0, 9) == 0);
      br_taken_EX = ($urandom_range(0, 4) == 0);
      excp_flush = ($urandom_range(0, 39) == 0);
      rstn = ($urandom_range(0, 199) != 0);
      settle("rnd");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage core (IF/ID/EX/MEM/WB). Detects load-use hazards that operand forwarding cannot cover, and stalls the front end for the multi-cycle divider occupying EX. Injects bubbles and flushes on taken branches and exceptions, and keeps a saturating stall-cycle counter. Sits beside the forwarding unit. Drives the stall and clear enables of the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
REG_LOG, 5, register index width
DIV_LAT, 16, divider latency in cycles (>=2)
CNT_W, 32, stall counter width

Ports:
clk  in  1  core clock
rstn  in  1  synchronous active-low reset
rs_ID  in  3*REG_LOG  {rs2,rs1,rs0} source indices of the instruction in ID
rs_use_ID  in  3  per-source "operand actually read" flags
rd_EX  in  REG_LOG  destination index of the instruction in EX
MEM_read_EX  in  1  instruction in EX is a load
div_start_EX  in  1  level; a div/mod instruction is in EX
br_taken_EX  in  1  taken branch/jump resolved in EX
excp_flush  in  1  exception/ertn commit from WB
stall_IF  out  1  hold PC
stall_ID  out  1  hold IF/ID
stall_EX  out  1  hold ID/EX
flush_ID  out  1  clear IF/ID next edge
flush_EX  out  1  clear ID/EX next edge
flush_MEM  out  1  clear EX/MEM next edge
div_done  out  1  divider result valid this cycle
state  out  2  IDLE=0, DIV_RUN=1, DIV_DONE=2
stall_cnt  out  CNT_W  cycles with stall_IF=1, saturating

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE, internal div counter=0, stall_cnt=0.
  - All control outputs are forced to 0 while rstn=0.
- Load-use (combinational):
  - lu = MEM_read_EX & |rd_EX & OR over i of (rs_use_ID[i] & rs_i==rd_EX).
  - While state=IDLE and lu=1: stall_IF=stall_ID=1 and flush_EX=1 (bubble into EX). The hazard clears one cycle later, when the load has moved to MEM.
- Divider FSM:
  - IDLE: div_start_EX=1 moves the FSM to DIV_RUN and loads the counter with DIV_LAT-1.
  - DIV_RUN: stall_IF=stall_ID=stall_EX=1 and flush_MEM=1 every cycle. The counter decrements each cycle. At counter==0 the FSM moves to DIV_DONE.
  - DIV_DONE, one cycle: div_done=1 and no stall. div_start_EX is ignored, because the same instruction is still in EX. The FSM always returns to IDLE.
  - Back-to-back divides: the second divide enters EX during the IDLE cycle that follows DONE and is accepted there.
  - The first stall cycle is the cycle in which div_start_EX is sampled in IDLE. This gives DIV_LAT+1 stall cycles in total, plus the DONE cycle.
- Taken branch (state=IDLE):
  - flush_ID=flush_EX=1 for that cycle. IF/ID and ID/EX hold wrong-path instructions.
  - It overrides load-use: no stall, and stall_IF=stall_ID=0.
  - br_taken_EX together with div_start_EX cannot occur; if it does, the divide takes precedence.
- excp_flush has the highest priority in any state:
  - flush_ID=flush_EX=flush_MEM=1, all stalls=0, div_done=0.
  - The FSM goes to IDLE next edge and any running divide is aborted.
- Priority order: rstn > excp_flush > DIV_RUN/DIV_DONE > br_taken_EX > load-use.
- stall_cnt increments on every edge where stall_IF=1 and saturates at all-ones. It is not cleared by excp_flush.
- All stall and flush outputs are combinational from the current state and inputs. state, the counter and stall_cnt are registered.

Test Plan:
- Load-use: rd_EX=5, MEM_read_EX=1, rs_ID rs1=5, rs_use_ID=3'b010 -> stall_IF=stall_ID=flush_EX=1 for exactly 1 cycle; stall_cnt=1. Repeat with rd_EX=0 -> no stall.
- Divide, DIV_LAT=16: div_start_EX held high -> stall_IF/ID/EX=1 and flush_MEM=1 for 17 cycles; then div_done=1 for 1 cycle with no stall; then state=IDLE; stall_cnt=17. A second divide immediately after -> another 17 stall cycles.
- Branch with a simultaneous load-use (rd_EX=3 matches rs0) and br_taken_EX=1 -> flush_ID=flush_EX=1, stall_IF=0.
- excp_flush on the 5th cycle of DIV_RUN -> all three flushes high that cycle; state=IDLE next cycle; div_done never asserts.
- rstn=0 mid-DIV_RUN for 1 cycle -> all outputs 0; state=0, stall_cnt=0 after the edge.
- Saturation: with CNT_W=4, hold a divide for 20 stall cycles -> stall_cnt stops at 15.
